// File: rtl/ml_ahb_prio_arb.sv
// ml_ahb_prio_arb -- registered priority arbiter for one multi-layer AHB slave port.
//
// Picks, at each arbitration point, the requesting master with the lowest
// priority value and presents it one cycle later as a one-hot grant plus a
// binary index. A locking owner keeps the port until it drops lock or req,
// or until it has held the port for LOCK_MAX cycles, at which point a
// re-arbitration is forced that excludes the owner.
//
// Build option:
//   ML_AHB_PRIO_RR_EN  defined   -> equal-priority ties rotate from rr_ptr
//                      undefined -> ties go to the lowest index (legacy)
module ml_ahb_prio_arb #(
    parameter int NUM_MST  = 4,
    parameter int PRIO_W   = 3,
    parameter int DEF_MST  = 0,
    parameter int LOCK_MAX = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [NUM_MST-1:0]          req,
    input  logic [NUM_MST-1:0]          lock,
    input  logic [NUM_MST*PRIO_W-1:0]   prio,
    input  logic                        hready,
    output logic [NUM_MST-1:0]          grant,
    output logic [$clog2(NUM_MST)-1:0]  grant_id,
    output logic                        grant_valid,
    output logic                        lock_timeout
);

    localparam int ID_W  = $clog2(NUM_MST);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic [ID_W-1:0]    DEF_ID    = ID_W'(DEF_MST);
    localparam logic [NUM_MST-1:0] DEF_GRANT = NUM_MST'(1) << DEF_MST;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // parked on DEF_MST, nobody asked
        ST_OWNED  = 2'd1,   // real owner, free to be pre-empted
        ST_LOCKED = 2'd2    // owner holds a lock
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [NUM_MST-1:0]  grant_q;
    logic [ID_W-1:0]     grant_id_q;
    logic                grant_valid_q;
    logic                lock_timeout_q;
    logic [CNT_W-1:0]    lock_cnt_q;
`ifdef ML_AHB_PRIO_RR_EN
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration decision (combinational)
    // ------------------------------------------------------------------
    logic                owner_req;
    logic                owner_lock;
    logic                locked_hold;   // owner still locked and requesting
    logic                timeout_hit;   // lock held for LOCK_MAX cycles
    logic                ap;            // arbitration point this cycle
    logic [NUM_MST-1:0]  cand;          // masters eligible to win
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [PRIO_W-1:0]   best_prio;
    logic [PRIO_W-1:0]   cur_prio;

    // Decide whether this cycle is an arbitration point and who would win it.
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so no latch can be inferred.
        owner_req   = req[grant_id_q];
        owner_lock  = lock[grant_id_q];
        locked_hold = (state_q == ST_LOCKED) && owner_req && owner_lock;
        timeout_hit = locked_hold && (lock_cnt_q == CNT_MAX);
        ap          = hready && (!locked_hold || timeout_hit);

        // A forced release must hand the port to someone else if possible.
        cand = req;
        if (timeout_hit) begin
            cand[grant_id_q] = 1'b0;
        end

        win_found = 1'b0;
        win_id    = DEF_ID;
        best_prio = '0;
        cur_prio  = '0;

`ifdef ML_AHB_PRIO_RR_EN
        // Scan upward from rr_ptr with wrap; strict '<' keeps the first tied
        // requester met in that order.
        for (int k = 0; k < NUM_MST; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_MST) begin
                idx = idx - NUM_MST;
            end
            cur_prio = prio[idx*PRIO_W +: PRIO_W];
            if (cand[idx] && (!win_found || (cur_prio < best_prio))) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
                best_prio = cur_prio;
            end
        end
`else
        // Scan from index 0; strict '<' leaves ties with the lowest index.
        for (int i = 0; i < NUM_MST; i++) begin
            cur_prio = prio[i*PRIO_W +: PRIO_W];
            if (cand[i] && (!win_found || (cur_prio < best_prio))) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                best_prio = cur_prio;
            end
        end
`endif
    end

`ifdef ML_AHB_PRIO_RR_EN
    // Next round-robin start: one past whoever ends up owning the port.
    always_comb begin
        logic [ID_W-1:0] base;
        base = win_found ? win_id : grant_id_q;
        if (base == ID_W'(NUM_MST - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = base + ID_W'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Arbitration FSM with registered grant outputs
    // ------------------------------------------------------------------
    // Owner, grant outputs, lock counter and timeout pulse advance together.
    always_ff @(posedge HCLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (HRESET) begin
            state_q        <= ST_IDLE;
            grant_q        <= DEF_GRANT;
            grant_id_q     <= DEF_ID;
            grant_valid_q  <= 1'b0;
            lock_timeout_q <= 1'b0;
            lock_cnt_q     <= '0;
`ifdef ML_AHB_PRIO_RR_EN
            rr_ptr_q       <= '0;
`endif
        end else begin
            lock_timeout_q <= 1'b0;
            if (ap) begin
                lock_timeout_q <= timeout_hit;
                if (win_found) begin
                    grant_q       <= NUM_MST'(1) << win_id;
                    grant_id_q    <= win_id;
                    grant_valid_q <= 1'b1;
                    if (lock[win_id]) begin
                        state_q    <= ST_LOCKED;
                        lock_cnt_q <= CNT_ONE;
                    end else begin
                        state_q    <= ST_OWNED;
                        lock_cnt_q <= '0;
                    end
`ifdef ML_AHB_PRIO_RR_EN
                    rr_ptr_q <= rr_ptr_d;
`endif
                end else if (timeout_hit) begin
                    // Nobody else wants the port: the owner keeps it, unlocked.
                    grant_valid_q <= 1'b1;
                    state_q       <= ST_OWNED;
                    lock_cnt_q    <= '0;
`ifdef ML_AHB_PRIO_RR_EN
                    rr_ptr_q      <= rr_ptr_d;
`endif
                end else begin
                    grant_q       <= DEF_GRANT;
                    grant_id_q    <= DEF_ID;
                    grant_valid_q <= 1'b0;
                    state_q       <= ST_IDLE;
                    lock_cnt_q    <= '0;
                end
            end else if (hready && locked_hold) begin
                lock_cnt_q <= lock_cnt_q + CNT_ONE;
            end
        end
    end

    assign grant        = grant_q;
    assign grant_id     = grant_id_q;
    assign grant_valid  = grant_valid_q;
    assign lock_timeout = lock_timeout_q;

    // Grant must stay one-hot and agree with its binary index.
    a_grant_onehot : assert property (@(posedge HCLK) disable iff (HRESET)
        $onehot(grant_q) && (grant_q == (NUM_MST'(1) << grant_id_q)));

endmodule

// File: tb/tb_ml_ahb_prio_arb.sv
// Self-checking bench for ml_ahb_prio_arb (NUM_MST=4, PRIO_W=3, DEF_MST=0,
// LOCK_MAX=4). A spec-level model predicts the outputs every cycle; directed
// vectors with hand-computed values pin the model itself.
module tb_ml_ahb_prio_arb;

    localparam int N    = 4;
    localparam int PW   = 3;
    localparam int DEF  = 0;
    localparam int LMAX = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [N*PW-1:0] prio;
    logic          hready;
    logic [N-1:0]  grant;
    logic [1:0]    grant_id;
    logic          grant_valid;
    logic          lock_timeout;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    ml_ahb_prio_arb #(
        .NUM_MST  (N),
        .PRIO_W   (PW),
        .DEF_MST  (DEF),
        .LOCK_MAX (LMAX)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req          (req),
        .lock         (lock),
        .prio         (prio),
        .hready       (hready),
        .grant        (grant),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid),
        .lock_timeout (lock_timeout)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the port, whether locked, how long held.
    // ------------------------------------------------------------------
    int m_owner  = DEF;
    int m_held   = 0;
    int m_rr     = 0;
    bit m_valid  = 1'b0;
    bit m_locked = 1'b0;
    bit m_tmo    = 1'b0;

    function automatic int prio_of(input int i);
        return int'(prio[i*PW +: PW]);
    endfunction

    task automatic model_step();
        bit holding;
        bit forced;
        int best;
        int best_key;
        int key;
        if (HRESET) begin
            m_owner = DEF; m_held = 0; m_rr = 0;
            m_valid = 1'b0; m_locked = 1'b0; m_tmo = 1'b0;
            return;
        end
        m_tmo = 1'b0;
        if (!hready) return;
        holding = m_locked && req[m_owner] && lock[m_owner];
        forced  = holding && (m_held == LMAX);
        if (holding && !forced) begin
            m_held++;
            return;
        end
        // Ranking key: priority first, then tie order (distance from rr_ptr
        // with round robin, plain index otherwise); smallest key wins.
        best     = -1;
        best_key = 1 << 30;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !(forced && i == m_owner)) begin
`ifdef ML_AHB_PRIO_RR_EN
                key = prio_of(i) * N + ((i - m_rr + N) % N);
`else
                key = prio_of(i) * N + i;
`endif
                if (key < best_key) begin
                    best_key = key;
                    best     = i;
                end
            end
        end
        m_tmo = forced;
        if (best >= 0) begin
            m_owner  = best;
            m_valid  = 1'b1;
            m_locked = lock[best];
            m_held   = lock[best] ? 1 : 0;
            m_rr     = (best + 1) % N;
        end else if (forced) begin
            m_valid  = 1'b1;
            m_locked = 1'b0;
            m_held   = 0;
            m_rr     = (m_owner + 1) % N;
        end else begin
            m_owner  = DEF;
            m_valid  = 1'b0;
            m_locked = 1'b0;
            m_held   = 0;
        end
    endtask

    initial forever begin
        @(posedge HCLK);
        model_step();
    end

    // Compare DUT against the model on every falling edge once reset is done.
    initial forever begin
        @(negedge HCLK);
        if (chk_en) begin
            check("grant",        int'(grant),        1 << m_owner);
            check("grant_id",     int'(grant_id),     m_owner);
            check("grant_valid",  int'(grant_valid),  int'(m_valid));
            check("lock_timeout", int'(lock_timeout), int'(m_tmo));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge HCLK);
    endtask

    task automatic set_prio(input int p0, input int p1, input int p2, input int p3);
        prio = {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    endtask

    int exp_tie [5];
    int hr_pat  [10] = '{0, 1, 0, 0, 1, 1, 0, 1, 1, 1};

    initial begin
`ifdef ML_AHB_PRIO_RR_EN
        exp_tie = '{0, 1, 2, 3, 0};
`else
        exp_tie = '{0, 0, 0, 0, 0};
`endif
        HRESET = 1'b1; req = '0; lock = '0; prio = '0; hready = 1'b1;
        repeat (2) tick();

        // Reset values
        HRESET = 1'b0;
        chk_en = 1'b1;
        check("rst_grant", int'(grant), 4'b0001);
        check("rst_id",    int'(grant_id), 0);
        check("rst_valid", int'(grant_valid), 0);
        check("rst_tmo",   int'(lock_timeout), 0);

        // Idle: parked on default master
        tick();
        check("idle_grant", int'(grant), 4'b0001);
        check("idle_valid", int'(grant_valid), 0);

        // Priority win: m1=5, m3=2 -> m3
        req = 4'b1010; set_prio(0, 5, 0, 2);
        tick();
        check("prio_grant", int'(grant), 4'b1000);
        check("prio_id",    int'(grant_id), 3);
        check("prio_valid", int'(grant_valid), 1);

        // Stall: m2 owns, hready low while m0 (prio 0) asks
        req = 4'b0100; set_prio(0, 5, 4, 2);
        tick();
        check("stall_own", int'(grant), 4'b0100);
        hready = 1'b0; req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_hold", int'(grant), 4'b0100);
        end
        hready = 1'b1;
        tick();
        check("stall_release", int'(grant), 4'b0001);
        check("stall_valid",   int'(grant_valid), 1);

        // Lock timeout with a competing master (m2 prio 0)
        req = 4'b0010; lock = 4'b0010; set_prio(0, 1, 0, 0);
        tick();
        check("lk_first", int'(grant), 4'b0010);
        req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("lk_hold",   int'(grant), 4'b0010);
            check("lk_no_tmo", int'(lock_timeout), 0);
        end
        tick();
        check("lk_tmo_pulse", int'(lock_timeout), 1);
        check("lk_switch",    int'(grant), 4'b0100);
        tick();
        check("lk_tmo_clear", int'(lock_timeout), 0);

        // Lock timeout with nobody else requesting: owner re-granted
        req = 4'b0010; lock = 4'b0010;
        tick();
        check("solo_lock", int'(grant), 4'b0010);
        repeat (3) tick();
        tick();
        check("solo_tmo",   int'(lock_timeout), 1);
        check("solo_grant", int'(grant), 4'b0010);
        check("solo_valid", int'(grant_valid), 1);
        tick();
        check("solo_tmo_clear", int'(lock_timeout), 0);

        // Lock count holds while hready is low; non-owner lock ignored until it wins
        req = 4'b0011; lock = 4'b0011; set_prio(0, 1, 0, 0);
        foreach (hr_pat[c]) begin
            hready = hr_pat[c][0];
            tick();
        end
        check("hr_lock_owner", int'(grant), 4'b0001);

        // Owner drops req during a stall: grant held until hready returns
        hready = 1'b0; req = '0; lock = '0;
        repeat (2) begin
            tick();
            check("drop_hold_valid", int'(grant_valid), 1);
        end
        hready = 1'b1;
        tick();
        check("drop_idle_valid", int'(grant_valid), 0);
        check("drop_idle_grant", int'(grant), 4'b0001);

        // Equal-priority ties from a fresh reset
        HRESET = 1'b1; req = 4'b1111; lock = '0; set_prio(3, 3, 3, 3);
        tick();
        HRESET = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("tie_id", int'(grant_id), exp_tie[c]);
        end

        // Reset while m2 holds a lock
        req = 4'b0100; lock = 4'b0100; set_prio(3, 3, 0, 3);
        tick();
        check("ml_lock", int'(grant), 4'b0100);
        tick();
        HRESET = 1'b1;
        tick();
        check("ml_rst_grant", int'(grant), 4'b0001);
        check("ml_rst_valid", int'(grant_valid), 0);
        check("ml_rst_tmo",   int'(lock_timeout), 0);
        HRESET = 1'b0; req = '0; lock = '0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
